// File: rtl/ooo_pkg.sv
// Shared rename-stage constants and types used by free_list, map_table and the ROB.
package ooo_pkg;

    localparam int PR_W     = 6;
    localparam int PR_NUM   = 64;
    localparam int ARCH_NUM = 32;
    localparam int DEPTH    = PR_NUM - ARCH_NUM;
    localparam int PTR_W    = $clog2(DEPTH);

    typedef logic [PR_W-1:0]  pr_t;
    typedef logic [PTR_W-1:0] fl_ptr_t;
    typedef logic [PR_W-1:0]  fl_cnt_t;

endpackage

// File: rtl/free_list.sv
// Physical-register free list: circular FIFO of free PR numbers with one pop
// (dispatch) and up to two pushes (retire, then recovery) per cycle.
module free_list
    import ooo_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    hazard_stall,
    input  logic    isDispatch,
    input  logic    RegDest,
    output pr_t     p_rd_new,
    output logic    fl_empty,
    input  logic    retire,
    input  logic    RegDest_retire,
    input  pr_t     PR_old_retire,
    input  logic    recover,
    input  logic    RegDest_ROB,
    input  pr_t     p_rd_recover,
    output fl_cnt_t fl_count,
    output logic    fl_err
);

    pr_t     r_mem [DEPTH];
    fl_ptr_t r_head;
    fl_ptr_t r_tail;
    fl_cnt_t r_count;
    logic    r_err;

    logic            w_pop_req;
    logic            w_pop;
    logic            w_push_a;
    logic            w_push_b;
    logic            w_acc_a;
    logic            w_acc_b;
    logic [PR_W:0]   w_room;
    fl_ptr_t         w_tail_b;
    fl_cnt_t         w_count_next;
    logic            w_err_set;

    // Same qualifier map_table uses to allocate a new destination mapping.
    assign w_pop_req = isDispatch && RegDest && !hazard_stall && !recover;
    assign w_pop     = w_pop_req && (r_count != '0);
    assign w_push_a  = retire && RegDest_retire;
    assign w_push_b  = recover && RegDest_ROB;

    // Free slots this cycle, counting the one vacated by a concurrent pop.
    assign w_room  = (PR_W+1)'(DEPTH) - {1'b0, r_count} + {{PR_W{1'b0}}, w_pop};
    assign w_acc_a = w_push_a && (w_room != '0);
    assign w_acc_b = w_push_b && (w_room > {{PR_W{1'b0}}, w_acc_a});

    assign w_tail_b     = w_acc_a ? r_tail + fl_ptr_t'(1) : r_tail;
    assign w_count_next = r_count + fl_cnt_t'(w_acc_a) + fl_cnt_t'(w_acc_b) - fl_cnt_t'(w_pop);

    assign w_err_set = (w_pop_req && (r_count == '0))
                     || (w_push_a && !w_acc_a)
                     || (w_push_b && !w_acc_b);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= pr_t'(ARCH_NUM + i);
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= fl_cnt_t'(DEPTH);
            r_err   <= 1'b0;
        end else begin
            if (w_acc_a) begin
                r_mem[r_tail] <= PR_old_retire;
            end
            if (w_acc_b) begin
                r_mem[w_tail_b] <= p_rd_recover;
            end
            if (w_pop) begin
                r_head <= r_head + fl_ptr_t'(1);
            end
            r_tail  <= r_tail + fl_ptr_t'(w_acc_a) + fl_ptr_t'(w_acc_b);
            r_count <= w_count_next;
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    assign p_rd_new = r_mem[r_head];
    assign fl_empty = (r_count == '0);
    assign fl_count = r_count;
    assign fl_err   = r_err;

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_free_list;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       hazard_stall = 1'b0;
    logic       isDispatch = 1'b0;
    logic       RegDest = 1'b0;
    logic [5:0] p_rd_new;
    logic       fl_empty;
    logic       retire = 1'b0;
    logic       RegDest_retire = 1'b0;
    logic [5:0] PR_old_retire = '0;
    logic       recover = 1'b0;
    logic       RegDest_ROB = 1'b0;
    logic [5:0] p_rd_recover = '0;
    logic [5:0] fl_count;
    logic       fl_err;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    int q[$];
    bit m_err;
    bit m_req;

    free_list dut (
        .clk            (clk),
        .rst            (rst),
        .hazard_stall   (hazard_stall),
        .isDispatch     (isDispatch),
        .RegDest        (RegDest),
        .p_rd_new       (p_rd_new),
        .fl_empty       (fl_empty),
        .retire         (retire),
        .RegDest_retire (RegDest_retire),
        .PR_old_retire  (PR_old_retire),
        .recover        (recover),
        .RegDest_ROB    (RegDest_ROB),
        .p_rd_recover   (p_rd_recover),
        .fl_count       (fl_count),
        .fl_err         (fl_err)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference: a queue of free PRs; pop from the front, retire then recover push to the back.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            for (int i = 0; i < 32; i++) q.push_back(32 + i);
            m_err = 0;
        end else begin
            m_req = isDispatch && RegDest && !hazard_stall && !recover;
            if (m_req) begin
                if (q.size() == 0) m_err = 1;
                else void'(q.pop_front());
            end
            if (retire && RegDest_retire) begin
                if (q.size() < 32) q.push_back(int'(PR_old_retire));
                else m_err = 1;
            end
            if (recover && RegDest_ROB) begin
                if (q.size() < 32) q.push_back(int'(p_rd_recover));
                else m_err = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst) begin
            chk("model_count", int'(fl_count), q.size());
            chk("model_empty", int'(fl_empty), int'(q.size() == 0));
            chk("model_err", int'(fl_err), int'(m_err));
            if (q.size() > 0) chk("model_p_rd_new", int'(p_rd_new), q[0]);
        end
    end

    task automatic step(input logic disp, input logic rd, input logic stall,
                        input logic ret, input logic rdr, input logic [5:0] pold,
                        input logic rec, input logic rdrob, input logic [5:0] prec);
        isDispatch = disp; RegDest = rd; hazard_stall = stall;
        retire = ret; RegDest_retire = rdr; PR_old_retire = pold;
        recover = rec; RegDest_ROB = rdrob; p_rd_recover = prec;
        @(posedge clk);
        @(negedge clk);
        isDispatch = 0; RegDest = 0; hazard_stall = 0;
        retire = 0; RegDest_retire = 0; PR_old_retire = '0;
        recover = 0; RegDest_ROB = 0; p_rd_recover = '0;
    endtask

    task automatic pop();
        step(1, 1, 0, 0, 0, 6'd0, 0, 0, 6'd0);
    endtask

    task automatic ret_pr(input logic [5:0] pr);
        step(0, 0, 0, 1, 1, pr, 0, 0, 6'd0);
    endtask

    task automatic do_reset();
        #1 rst = 0;
        @(negedge clk);
        #2 rst = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst = 0;
        @(negedge clk);
        #2 rst = 1;
        chk_en = 1;

        chk("rst_p_rd_new", int'(p_rd_new), 32);
        chk("rst_count", int'(fl_count), 32);
        chk("rst_empty", int'(fl_empty), 0);
        chk("rst_err", int'(fl_err), 0);

        step(1, 1, 1, 0, 0, 6'd0, 0, 0, 6'd0);
        chk("stall_p_rd_new", int'(p_rd_new), 32);
        chk("stall_count", int'(fl_count), 32);
        step(1, 1, 0, 0, 0, 6'd0, 1, 0, 6'd0);
        chk("recover_p_rd_new", int'(p_rd_new), 32);
        chk("recover_count", int'(fl_count), 32);

        for (int i = 0; i < 32; i++) begin
            chk("drain_seq", int'(p_rd_new), 32 + i);
            pop();
        end
        chk("drain_empty", int'(fl_empty), 1);
        chk("drain_count", int'(fl_count), 0);
        chk("drain_err_clear", int'(fl_err), 0);
        pop();
        chk("pop_empty_err", int'(fl_err), 1);
        chk("pop_empty_count", int'(fl_count), 0);

        do_reset();
        for (int i = 0; i < 32; i++) pop();
        ret_pr(6'd5);
        chk("refill_empty", int'(fl_empty), 0);
        chk("refill_p_rd_new", int'(p_rd_new), 5);
        chk("refill_count", int'(fl_count), 1);

        pop();
        ret_pr(6'd40);
        chk("head40", int'(p_rd_new), 40);
        step(1, 1, 0, 1, 1, 6'd7, 0, 0, 6'd0);
        chk("poppush_p_rd_new", int'(p_rd_new), 7);
        chk("poppush_count", int'(fl_count), 1);

        do_reset();
        for (int i = 0; i < 32; i++) pop();
        for (int i = 0; i < 30; i++) ret_pr(6'(i));
        for (int i = 0; i < 20; i++) pop();
        chk("wrap_pre_count", int'(fl_count), 10);
        step(0, 0, 0, 1, 1, 6'd3, 1, 1, 6'd50);
        chk("wrap_count", int'(fl_count), 12);
        for (int i = 0; i < 10; i++) begin
            chk("wrap_seq", int'(p_rd_new), 20 + i);
            pop();
        end
        chk("wrap_mem30", int'(p_rd_new), 3);
        pop();
        chk("wrap_mem31", int'(p_rd_new), 50);
        pop();
        chk("wrap_drained", int'(fl_empty), 1);
        ret_pr(6'd17);
        chk("wrap_tail0", int'(p_rd_new), 17);

        do_reset();
        pop();
        chk("full_pre_count", int'(fl_count), 31);
        step(0, 0, 0, 1, 1, 6'd9, 1, 1, 6'd12);
        chk("full_count", int'(fl_count), 32);
        chk("full_err", int'(fl_err), 1);
        for (int i = 0; i < 31; i++) pop();
        chk("full_accepted", int'(p_rd_new), 9);
        chk("full_last_count", int'(fl_count), 1);

        #3 rst = 0;
        #1;
        chk("midrst_p_rd_new", int'(p_rd_new), 32);
        chk("midrst_count", int'(fl_count), 32);
        chk("midrst_err", int'(fl_err), 0);
        chk("midrst_empty", int'(fl_empty), 0);
        @(negedge clk);
        #2 rst = 1;
        pop();
        chk("post_rst_pop", int'(p_rd_new), 33);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
